vga_sync_decoder: RTL

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

---
 rtl/vga_dec_pkg.sv | 27 ++
 rtl/vga_edge_det.sv | 43 ++++
 rtl/vga_sync_decoder.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_dec_pkg.sv
// ---------------------------------------------------------------------------
// vga_dec_pkg
// Shared types and constants for the VGA sync decoder.
//   dec_state_e : decoder lock state (HUNT -> ALIGN -> LOCKED)
//   err_code_e  : error code reported on ERR_CODE, higher value wins
//   H_TOTAL_W   : width of the measured line period output
//   V_TOTAL_W   : width of the measured frame period output
// ---------------------------------------------------------------------------
package vga_dec_pkg;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_LOCKED = 2'd2
    } dec_state_e;

    typedef enum logic [1:0] {
        ERR_NONE        = 2'd0,
        ERR_LINE_LEN    = 2'd1,
        ERR_FRAME_LEN   = 2'd2,
        ERR_SYNC_ACTIVE = 2'd3
    } err_code_e;

    localparam int H_TOTAL_W = 12;
    localparam int V_TOTAL_W = 11;

endpackage

// File: rtl/vga_edge_det.sv
// ---------------------------------------------------------------------------
// vga_edge_det
// Registers one sync/blank input and flags a falling edge between the
// previous and the current sample. Both outputs describe the same sample.
// Ports:
//   clk_i   : pixel clock
//   rst_ni  : synchronous active-low reset
//   sig_i   : raw input
//   level_o : registered sample of sig_i
//   fall_o  : one-cycle pulse, sample went 1 -> 0
// ---------------------------------------------------------------------------
module vga_edge_det #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sig_i,
    output logic level_o,
    output logic fall_o
);

    logic level_q;
    logic fall_q;

    // NOTE: reset is sampled on the clock edge (synchronous); every state
    // register is listed in the reset branch so nothing powers up unknown.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            // History clears to the idle (high) level so a held-low input
            // after reset is seen as a fresh falling edge.
            level_q <= RESET_VAL;
            fall_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so fall_q sees the old level_q.
            level_q <= sig_i;
            fall_q  <= level_q & ~sig_i;
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// ---------------------------------------------------------------------------
// vga_sync_decoder
// Locks onto a VGA-style HS/VS/BLANK stream and reports pixel coordinates,
// frame starts and timing errors. Every output is registered: an input
// sampled at edge k is reflected on the outputs after edge k+1.
//
// Ports:
//   CLK         : pixel clock, rising edge
//   RST         : synchronous active-low reset
//   VGA_HS      : horizontal sync, active low
//   VGA_VS      : vertical sync, active low
//   VGA_BLANK   : high during active display pixels
//   PIX_VALID   : active pixel while not in HUNT
//   PIX_X/PIX_Y : pixel column / row
//   FRAME_START : one-cycle pulse on a VS falling edge while LOCKED
//   LOCKED      : decoder is in LOCKED
//   ERR         : one-cycle error pulse
//   ERR_CODE    : last error code (see err_code_e), held until next error
//   H_TOTAL     : measured line period in cycles
//   V_TOTAL     : measured frame period in lines
//
// Build option: define VGA_DEC_MEASURE_EN to enable H_TOTAL/V_TOTAL
// measurement; otherwise both outputs are tied to zero.
// ---------------------------------------------------------------------------
module vga_sync_decoder
    import vga_dec_pkg::*;
#(
    parameter int HDISP = 640,
    parameter int VDISP = 480
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       VGA_HS,
    input  logic                       VGA_VS,
    input  logic                       VGA_BLANK,
    output logic                       PIX_VALID,
    output logic [$clog2(HDISP)-1:0]   PIX_X,
    output logic [$clog2(VDISP)-1:0]   PIX_Y,
    output logic                       FRAME_START,
    output logic                       LOCKED,
    output logic                       ERR,
    output logic [1:0]                 ERR_CODE,
    output logic [H_TOTAL_W-1:0]       H_TOTAL,
    output logic [V_TOTAL_W-1:0]       V_TOTAL
);

    localparam int XW  = $clog2(HDISP);
    localparam int YW  = $clog2(VDISP);
    // Counters reach HDISP / VDISP exactly so overruns can be detected.
    localparam int XCW = $clog2(HDISP + 1);
    localparam int LCW = $clog2(VDISP + 1);
    localparam logic [XCW-1:0] X_MAX = XCW'(HDISP);
    localparam logic [LCW-1:0] L_MAX = LCW'(VDISP);

    // ------------------------------------------------------------------
    // Input sampling and falling-edge detection
    // ------------------------------------------------------------------
    logic hs_lvl, hs_fall;
    logic vs_lvl, vs_fall;
    logic bl_lvl, bl_fall;

    vga_edge_det u_hs_det (
        .clk_i   (CLK),
        .rst_ni  (RST),
        .sig_i   (VGA_HS),
        .level_o (hs_lvl),
        .fall_o  (hs_fall)
    );

    vga_edge_det u_vs_det (
        .clk_i   (CLK),
        .rst_ni  (RST),
        .sig_i   (VGA_VS),
        .level_o (vs_lvl),
        .fall_o  (vs_fall)
    );

    vga_edge_det u_bl_det (
        .clk_i   (CLK),
        .rst_ni  (RST),
        .sig_i   (VGA_BLANK),
        .level_o (bl_lvl),
        .fall_o  (bl_fall)
    );

    // ------------------------------------------------------------------
    // State and counters
    // ------------------------------------------------------------------
    dec_state_e       state_q;
    logic             frame_err_q;
    logic [XCW-1:0]   x_q, x_d;
    logic [LCW-1:0]   line_q, line_d;

    logic             pix_valid_q;
    logic [XW-1:0]    pix_x_q;
    logic [YW-1:0]    pix_y_q;
    logic             frame_start_q;
    logic             locked_q;
    logic             err_q;
    err_code_e        err_code_q;

    logic             line_len_err;
    logic             frame_len_err;
    logic             sync_err;
    logic             any_err;
    logic             pixel_ok;
    err_code_e        err_code_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned (which would infer a latch).
        x_d           = x_q;
        line_d        = line_q;
        err_code_d    = ERR_NONE;

        // x holds the number of BLANK-high cycles since the last BLANK fall
        // and saturates at HDISP, which is itself the overrun marker.
        if (bl_fall) begin
            x_d = '0;
        end else if (bl_lvl && (x_q != X_MAX)) begin
            x_d = x_q + XCW'(1);
        end

        if (vs_fall) begin
            line_d = '0;
        end else if (bl_fall && (line_q != L_MAX)) begin
            line_d = line_q + LCW'(1);
        end

        line_len_err  = (bl_fall && (x_q != X_MAX)) || (bl_lvl && (x_q == X_MAX));
        frame_len_err = (vs_fall && (line_q != L_MAX) && (state_q != ST_HUNT))
                      || (bl_fall && (line_q == L_MAX));
        sync_err      = bl_lvl && (!hs_lvl || !vs_lvl);
        // HUNT ignores all errors; it only waits for a VS falling edge.
        any_err       = (state_q != ST_HUNT) && (line_len_err || frame_len_err || sync_err);

        if (sync_err) begin
            err_code_d = ERR_SYNC_ACTIVE;
        end else if (frame_len_err) begin
            err_code_d = ERR_FRAME_LEN;
        end else if (line_len_err) begin
            err_code_d = ERR_LINE_LEN;
        end

        // A pixel is only reported while it lies inside the expected
        // raster and does not overlap a sync pulse.
        pixel_ok = bl_lvl && (x_q != X_MAX) && (line_q != L_MAX) && !sync_err;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q       <= ST_HUNT;
            frame_err_q   <= 1'b0;
            x_q           <= '0;
            line_q        <= '0;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            err_q         <= 1'b0;
            err_code_q    <= ERR_NONE;
        end else begin
            x_q           <= x_d;
            line_q        <= line_d;
            pix_valid_q   <= (state_q != ST_HUNT) && pixel_ok;
            if (pixel_ok) begin
                pix_x_q <= x_q[XW-1:0];
                pix_y_q <= line_q[YW-1:0];
            end
            err_q         <= any_err;
            if (any_err) begin
                err_code_q <= err_code_d;
            end
            frame_start_q <= 1'b0;

            unique case (state_q)
                ST_HUNT: begin
                    if (vs_fall) begin
                        state_q     <= ST_ALIGN;
                        frame_err_q <= 1'b0;
                    end
                end
                ST_ALIGN: begin
                    // An error on the closing VS edge counts against the
                    // frame it closes, so the frame is retried.
                    if (vs_fall) begin
                        frame_err_q <= 1'b0;
                        if (!(frame_err_q || any_err)) begin
                            state_q  <= ST_LOCKED;
                            locked_q <= 1'b1;
                        end
                    end else if (any_err) begin
                        frame_err_q <= 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (any_err) begin
                        state_q  <= ST_HUNT;
                        locked_q <= 1'b0;
                    end else if (vs_fall) begin
                        frame_start_q <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= ST_HUNT;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign PIX_VALID   = pix_valid_q;
    assign PIX_X       = pix_x_q;
    assign PIX_Y       = pix_y_q;
    assign FRAME_START = frame_start_q;
    assign LOCKED      = locked_q;
    assign ERR         = err_q;
    assign ERR_CODE    = err_code_q;

    // ------------------------------------------------------------------
    // Optional line/frame period measurement
    // ------------------------------------------------------------------
`ifdef VGA_DEC_MEASURE_EN
    logic [H_TOTAL_W-1:0] hcnt_q, hcnt_d, h_total_q;
    logic [V_TOTAL_W-1:0] vcnt_q, vcnt_d, v_total_q;

    always_comb begin
        // hcnt counts cycles including the current one since the last HS
        // fall; vcnt counts HS falls since the last VS fall (an HS fall on
        // the VS edge belongs to the new frame).
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (hs_fall) begin
            hcnt_d = H_TOTAL_W'(1);
        end else if (hcnt_q != '1) begin
            hcnt_d = hcnt_q + H_TOTAL_W'(1);
        end
        if (vs_fall) begin
            vcnt_d = V_TOTAL_W'(hs_fall);
        end else if (hs_fall && (vcnt_q != '1)) begin
            vcnt_d = vcnt_q + V_TOTAL_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            h_total_q <= '0;
            v_total_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            if (hs_fall) begin
                h_total_q <= hcnt_q;
            end
            if (vs_fall) begin
                v_total_q <= vcnt_q;
            end
        end
    end

    assign H_TOTAL = h_total_q;
    assign V_TOTAL = v_total_q;
`else
    logic unused_hs_fall;
    assign unused_hs_fall = hs_fall;
    assign H_TOTAL        = '0;
    assign V_TOTAL        = '0;
`endif

endmodule
